// File: rtl/t2mi_from_ts_if.sv
// t2mi_from_ts_if: TS byte stream in and T2-MI byte stream out of the T2-MI extractor
interface t2mi_from_ts_if;
    logic [7:0] DATA_IN;
    logic       ENA_IN;
    logic       PSYNC_IN;
    logic [7:0] DATA_OUT;
    logic       ENA_OUT;
    logic       T2MI_START;
    modport master (output DATA_IN, ENA_IN, PSYNC_IN, input DATA_OUT, ENA_OUT, T2MI_START);
    modport slave  (input DATA_IN, ENA_IN, PSYNC_IN, output DATA_OUT, ENA_OUT, T2MI_START);
endinterface

// File: rtl/t2mi_from_ts.sv
// t2mi_from_ts: extracts T2-MI payload bytes from 188-byte TS packets; define T2MI_CC_CHECK_EN for continuity checking
module t2mi_from_ts (
    input  logic          CLK,
    input  logic          RST,
    t2mi_from_ts_if.slave ts,
    input  logic [12:0]   t2mi_pid,
    output logic          SYNC_ERR,
    output logic          CC_ERR,
    output logic [3:0]    state_mon
);
    localparam logic [3:0] IDLE = 4'd0, HDR = 4'd1, AF_LEN = 4'd2, AF_SKIP = 4'd3,
                           POINTER = 4'd4, PAYLOAD = 4'd5, DROP = 4'd6;
    logic [3:0]  state, state_n, body;
    logic [7:0]  byte_idx, af_cnt, ptr_cnt;
    logic [12:0] pid;
    logic        tei, pusi, pend, aligned;
    logic        ena, sync_ok, hdr_dec, hdr_bad, ptr_ovr;
    logic        emit, start, sync_err_n, cc_err_n, cc_dup;
    assign ena       = ts.ENA_IN;
    assign sync_ok   = ena & ts.PSYNC_IN & (ts.DATA_IN == 8'h47);
    assign hdr_dec   = ena & ~sync_ok & (state == HDR) & (byte_idx == 8'd3);
    assign hdr_bad   = tei | (pid != t2mi_pid) | ~ts.DATA_IN[4];
    assign ptr_ovr   = ena & ~sync_ok & (state == POINTER) & (ts.DATA_IN >= 8'd187 - byte_idx);
    assign body      = pusi ? POINTER : PAYLOAD;
    assign state_mon = state;
`ifdef T2MI_CC_CHECK_EN
    logic [3:0] cc_last;
    logic       cc_chk;
    // aligned can only be set after an accepted header, so it also marks the CC history as valid
    assign cc_chk   = aligned & hdr_dec & ~hdr_bad;
    assign cc_dup   = cc_chk & (ts.DATA_IN[3:0] == cc_last);
    assign cc_err_n = cc_chk & ~cc_dup & (ts.DATA_IN[3:0] != cc_last + 4'd1);
    // remember the CC of the most recent accepted header
    always_ff @(posedge CLK)
        if (RST) cc_last <= 4'd0;
        else if (hdr_dec & ~hdr_bad) cc_last <= ts.DATA_IN[3:0];
`else
    assign cc_dup   = 1'b0;
    assign cc_err_n = 1'b0;
`endif
    // state register
    always_ff @(posedge CLK)
        state <= RST ? IDLE : state_n;
    // next state; a valid sync always restarts, byte 187 always ends the packet
    always_comb begin
        state_n = state;
        if (ena) begin
            if (sync_ok) state_n = HDR;
            else if (state != IDLE && byte_idx == 8'd187) state_n = IDLE;
            else case (state)
                HDR:     if (byte_idx == 8'd3) state_n = (hdr_bad | cc_dup) ? DROP : ts.DATA_IN[5] ? AF_LEN : body;
                AF_LEN:  state_n = (ts.DATA_IN >= 8'd183) ? DROP : (ts.DATA_IN == 8'd0) ? body : AF_SKIP;
                AF_SKIP: if (af_cnt == 8'd1) state_n = body;
                POINTER: state_n = ptr_ovr ? DROP : PAYLOAD;
                default: ;
            endcase
        end
    end
    // output decode; the first byte after the pointer countdown starts a T2-MI packet
    always_comb begin
        start      = ena & ~sync_ok & (state == PAYLOAD) & pend & (ptr_cnt == 8'd0);
        emit       = ena & ~sync_ok & (state == PAYLOAD) & (aligned | start);
        sync_err_n = ena & ts.PSYNC_IN & ((state == IDLE) ? (ts.DATA_IN != 8'h47) : sync_ok);
    end
    // packet position, header fields, skip/pointer counters and alignment
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_idx <= 8'd0;
            tei      <= 1'b0;
            pusi     <= 1'b0;
            pid      <= 13'd0;
            af_cnt   <= 8'd0;
            ptr_cnt  <= 8'd0;
            pend     <= 1'b0;
            aligned  <= 1'b0;
        end else begin
            if (ena) begin
                byte_idx <= sync_ok ? 8'd1 : (state == IDLE || byte_idx == 8'd187) ? 8'd0 : byte_idx + 8'd1;
                if (state == HDR && !sync_ok && byte_idx == 8'd1) {tei, pusi, pid[12:8]} <= {ts.DATA_IN[7:6], ts.DATA_IN[4:0]};
                if (state == HDR && !sync_ok && byte_idx == 8'd2) pid[7:0] <= ts.DATA_IN;
                if (state == AF_LEN) af_cnt <= ts.DATA_IN;
                else if (state == AF_SKIP) af_cnt <= af_cnt - 8'd1;
                if (state == POINTER) ptr_cnt <= ts.DATA_IN;
                else if (state == PAYLOAD && pend && ptr_cnt != 8'd0) ptr_cnt <= ptr_cnt - 8'd1;
                pend <= sync_ok ? 1'b0 : (state == POINTER) ? 1'b1 : start ? 1'b0 : pend;
            end
            aligned <= (aligned | start) & ~(sync_err_n | cc_err_n | ptr_ovr);
        end
    end
    // registered outputs, one cycle after the input byte
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts.DATA_OUT   <= 8'h00;
            ts.ENA_OUT    <= 1'b0;
            ts.T2MI_START <= 1'b0;
            SYNC_ERR      <= 1'b0;
            CC_ERR        <= 1'b0;
        end else begin
            ts.ENA_OUT    <= emit;
            ts.T2MI_START <= start;
            SYNC_ERR      <= sync_err_n;
            CC_ERR        <= cc_err_n;
            if (emit) ts.DATA_OUT <= ts.DATA_IN;
        end
    end
endmodule

// File: tb/tb_t2mi_from_ts.sv
// tb_t2mi_from_ts: directed self-checking bench for t2mi_from_ts
module tb_t2mi_from_ts;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [12:0] t2mi_pid = 13'h1000;
    logic        SYNC_ERR, CC_ERR;
    logic [3:0]  state_mon;
    t2mi_from_ts_if bus();
    t2mi_from_ts dut (.CLK(CLK), .RST(RST), .ts(bus), .t2mi_pid(t2mi_pid),
                      .SYNC_ERR(SYNC_ERR), .CC_ERR(CC_ERR), .state_mon(state_mon));
    int checks = 0;
    int errors = 0;
    int n_sync = 0;
    int n_cc = 0;
    bit gaps = 1'b0;
    logic [7:0] q_data[$];
    bit         q_start[$];
    always #5 CLK = ~CLK;
    // record every output byte and error pulse shortly after each edge
    always @(posedge CLK) begin
        #1;
        if (bus.ENA_OUT) begin
            q_data.push_back(bus.DATA_OUT);
            q_start.push_back(bus.T2MI_START);
        end
        if (SYNC_ERR) n_sync++;
        if (CC_ERR) n_cc++;
    end
    task automatic clr();
        q_data.delete();
        q_start.delete();
    endtask
    task automatic send(input logic [7:0] d, input logic s);
        if (gaps) repeat ($urandom_range(0, 1)) begin
            bus.ENA_IN = 1'b0;
            bus.PSYNC_IN = 1'b0;
            @(negedge CLK);
        end
        bus.DATA_IN = d;
        bus.PSYNC_IN = s;
        bus.ENA_IN = 1'b1;
        @(negedge CLK);
        bus.ENA_IN = 1'b0;
        bus.PSYNC_IN = 1'b0;
    endtask
    // payload byte k after the pointer field carries value k
    task automatic send_pkt(input logic [12:0] pid, input logic pusi, input logic [1:0] afc,
                            input logic [3:0] cc, input int len, input int ptr, input int nb);
        logic [7:0] pk [188];
        int i, k;
        pk[0] = 8'h47;
        pk[1] = {1'b0, pusi, 1'b0, pid[12:8]};
        pk[2] = pid[7:0];
        pk[3] = {2'b00, afc, cc};
        i = 4;
        if (afc[1]) begin
            pk[4] = len[7:0];
            i = 5;
            for (int j = 0; j < len && i < 188; j++) begin
                pk[i] = 8'hFF;
                i++;
            end
        end
        if (pusi && afc[0] && i < 188) begin
            pk[i] = ptr[7:0];
            i++;
        end
        k = 0;
        while (i < 188) begin
            pk[i] = 8'(k);
            i++;
            k++;
        end
        for (int j = 0; j < nb; j++) send(pk[j], j == 0);
    endtask
    task automatic test_reset();
        bus.DATA_IN = 8'h00;
        bus.ENA_IN = 1'b0;
        bus.PSYNC_IN = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.ENA_OUT, bus.T2MI_START, SYNC_ERR, CC_ERR} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {bus.ENA_OUT, bus.T2MI_START, SYNC_ERR, CC_ERR});
        end
        checks++;
        if (bus.DATA_OUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h want 00", bus.DATA_OUT);
        end
        checks++;
        if (state_mon !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state_mon);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask
    task automatic test_basic();
        int bad;
        clr();
        send(8'h47, 1'b1);
        send(8'h50, 1'b0);
        send(8'h00, 1'b0);
        send(8'h10, 1'b0);
        send(8'h00, 1'b0);
        for (int k = 0; k < 183; k++) begin
            send(8'(k), 1'b0);
            if (k == 0) begin
                checks++;
                if ({bus.ENA_OUT, bus.T2MI_START, bus.DATA_OUT} !== {2'b11, 8'h00}) begin
                    errors++;
                    $display("FAIL basic_latency got ena=%b st=%b d=%h want ena=1 st=1 d=00", bus.ENA_OUT, bus.T2MI_START, bus.DATA_OUT);
                end
            end
        end
        @(negedge CLK);
        checks++;
        if (bus.ENA_OUT !== 1'b0) begin
            errors++;
            $display("FAIL basic_tail got ena=%b want 0", bus.ENA_OUT);
        end
        checks++;
        if (q_data.size() != 183) begin
            errors++;
            $display("FAIL basic_len got %0d want 183", q_data.size());
        end
        bad = 0;
        foreach (q_data[i]) if (q_data[i] !== 8'(i) || q_start[i] !== (i == 0)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_bytes got %0d wrong bytes want 0", bad);
        end
        checks++;
        if (state_mon !== 4'd0) begin
            errors++;
            $display("FAIL basic_idle got %0d want 0", state_mon);
        end
    endtask
    task automatic test_sync();
        int n0;
        n0 = n_sync;
        send(8'h48, 1'b1);
        checks++;
        if (n_sync != n0 + 1 || state_mon !== 4'd0) begin
            errors++;
            $display("FAIL sync_bad got pulses=%0d state=%0d want 1 0", n_sync - n0, state_mon);
        end
        @(negedge CLK);
        checks++;
        if (SYNC_ERR !== 1'b0) begin
            errors++;
            $display("FAIL sync_pulse got %b want 0", SYNC_ERR);
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd1, 0, 0, 100);
        checks++;
        if (q_data.size() != 95) begin
            errors++;
            $display("FAIL sync_partial got %0d want 95", q_data.size());
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd2, 0, 3, 188);
        checks++;
        if (n_sync != n0 + 2) begin
            errors++;
            $display("FAIL sync_early got %0d want %0d", n_sync, n0 + 2);
        end
        checks++;
        if (q_data.size() != 180 || q_data[0] !== 8'd3 || q_start[0] !== 1'b1 || q_data[179] !== 8'd182) begin
            errors++;
            $display("FAIL sync_newpkt got len=%0d first=%h want 180 03", q_data.size(), q_data.size() ? q_data[0] : 8'h00);
        end
    endtask
    task automatic test_af_pointer();
        int ns;
        send(8'h48, 1'b1);
        clr();
        send_pkt(13'h1000, 1'b1, 2'b11, 4'd3, 10, 5, 188);
        ns = 0;
        foreach (q_start[i]) ns += int'(q_start[i]);
        checks++;
        if (q_data.size() != 167 || q_data[0] !== 8'd5 || q_start[0] !== 1'b1 || q_data[166] !== 8'd171 || ns != 1) begin
            errors++;
            $display("FAIL af_unaligned got len=%0d starts=%0d want 167 1", q_data.size(), ns);
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b11, 4'd4, 10, 5, 188);
        checks++;
        if (q_data.size() != 172 || q_data[0] !== 8'd0 || q_start[0] !== 1'b0) begin
            errors++;
            $display("FAIL af_aligned got len=%0d want 172", q_data.size());
        end
        checks++;
        if (q_data.size() < 6 || q_data[5] !== 8'd5 || q_start[5] !== 1'b1) begin
            errors++;
            $display("FAIL af_start got start=%b want 1", q_start.size() > 5 ? q_start[5] : 1'b0);
        end
    endtask
    task automatic test_pid_drop();
        clr();
        send_pkt(13'h1FFF, 1'b1, 2'b01, 4'd4, 0, 0, 10);
        checks++;
        if (state_mon !== 4'd6) begin
            errors++;
            $display("FAIL pid_state got %0d want 6", state_mon);
        end
        repeat (178) send(8'h00, 1'b0);
        send_pkt(13'h1000, 1'b0, 2'b11, 4'd5, 183, 0, 10);
        checks++;
        if (state_mon !== 4'd6) begin
            errors++;
            $display("FAIL afonly_state got %0d want 6", state_mon);
        end
        repeat (178) send(8'hFF, 1'b0);
        checks++;
        if (q_data.size() != 0 || state_mon !== 4'd0) begin
            errors++;
            $display("FAIL drop_out got len=%0d state=%0d want 0 0", q_data.size(), state_mon);
        end
    endtask
    task automatic test_cc();
        int nc, want_dup, want_err, want_len;
`ifdef T2MI_CC_CHECK_EN
        want_dup = 0;
        want_err = 1;
        want_len = 178;
`else
        want_dup = 183;
        want_err = 0;
        want_len = 183;
`endif
        send(8'h48, 1'b1);
        nc = n_cc;
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd3, 0, 5, 188);
        checks++;
        if (q_data.size() != 178) begin
            errors++;
            $display("FAIL cc3 got %0d want 178", q_data.size());
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd4, 0, 5, 188);
        checks++;
        if (q_data.size() != 183) begin
            errors++;
            $display("FAIL cc4 got %0d want 183", q_data.size());
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd4, 0, 5, 188);
        checks++;
        if (q_data.size() != want_dup) begin
            errors++;
            $display("FAIL cc_dup got %0d want %0d", q_data.size(), want_dup);
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd6, 0, 5, 188);
        checks++;
        if (q_data.size() != want_len || q_start[0] !== (want_len == 178)) begin
            errors++;
            $display("FAIL cc6 got %0d want %0d", q_data.size(), want_len);
        end
        checks++;
        if (n_cc - nc != want_err) begin
            errors++;
            $display("FAIL cc_err got %0d want %0d", n_cc - nc, want_err);
        end
    endtask
    task automatic test_gaps();
        int bad;
        for (int p = 0; p < 2; p++) begin
            gaps = (p == 1);
            clr();
            send_pkt(13'h1000, 1'b1, 2'b01, 4'(7 + p), 0, 2, 188);
            gaps = 1'b0;
            bad = (q_data.size() != 183) ? 1 : 0;
            foreach (q_data[i]) if (q_data[i] !== 8'(i) || q_start[i] !== (i == 2)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL gaps%0d got %0d bad (len %0d) want 0", p, bad, q_data.size());
            end
        end
    endtask
    task automatic test_reset_mid();
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd9, 0, 0, 50);
        checks++;
        if (bus.ENA_OUT !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got %b want 1", bus.ENA_OUT);
        end
        RST = 1'b1;
        bus.DATA_IN = 8'h33;
        bus.ENA_IN = 1'b1;
        @(negedge CLK);
        checks++;
        if ({bus.ENA_OUT, bus.T2MI_START, SYNC_ERR, CC_ERR, bus.DATA_OUT, state_mon} !== 16'h0) begin
            errors++;
            $display("FAIL rst_mid got %h want 0000", {bus.ENA_OUT, bus.T2MI_START, SYNC_ERR, CC_ERR, bus.DATA_OUT, state_mon});
        end
        RST = 1'b0;
        bus.ENA_IN = 1'b0;
        clr();
        repeat (20) send(8'h55, 1'b0);
        checks++;
        if (q_data.size() != 0 || state_mon !== 4'd0) begin
            errors++;
            $display("FAIL rst_resume got len=%0d state=%0d want 0 0", q_data.size(), state_mon);
        end
        clr();
        send_pkt(13'h1000, 1'b1, 2'b01, 4'd0, 0, 0, 188);
        checks++;
        if (q_data.size() != 183 || q_start[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_after got len=%0d want 183", q_data.size());
        end
    endtask
    initial begin
        @(negedge CLK);
        test_reset();
        test_basic();
        test_sync();
        test_af_pointer();
        test_pid_drop();
        test_cc();
        test_gaps();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
